alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Parametrised, registered successor to the two-input prueba cell: a WIDTH-bit ALU with
//   valid/ready handshakes on both sides. Logic/add/shift ops finish in one cycle; MUL runs
//   on an iterative shift-add engine. Sits between operand sequencer and writeback stage.
// PARAMETERS
//   WIDTH   8  operand width in bits, >=4
//   MUL_EN  1  1 = iterative multiplier present; 0 = MUL reports err
// PORTS
//   clk        in   1          rising-edge clock, single domain
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          operand/op request valid
//   in_ready   out  1          ALU can accept a request
//   op         in   3          0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 MUL
//   a          in   WIDTH      operand A
//   b          in   WIDTH      operand B; shifts use b[$clog2(WIDTH)-1:0]
//   out_valid  out  1          result valid, held until out_ready
//   out_ready  in   1          consumer accepts result
//   result     out  WIDTH      low result word
//   result_hi  out  WIDTH      MUL high word; 0 for all other ops
//   flags      out  4          {N,V,C,Z}
//   err        out  1          MUL requested with MUL_EN=0
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; in_ready=0 while rst_n=0, then 1 on the first clock
//     after release; out_valid, result, result_hi, flags, err = 0.
//   FSM IDLE -> (accept, op!=MUL or !MUL_EN) -> DONE; IDLE -> (accept, MUL) -> CALC;
//     CALC -> (bit counter==WIDTH-1) -> DONE; DONE -> (out_ready) -> IDLE.
//   Accept = in_valid & in_ready; in_ready=1 only in IDLE; a,b,op are latched on accept.
//   Latency: single-cycle ops set out_valid the cycle after accept; MUL sets out_valid
//     WIDTH+1 cycles after accept. Throughput: one request per 2 cycles minimum (1-cycle ops).
//   out_valid and every output stay stable while out_valid=1 and out_ready=0.
//   out_valid & out_ready in DONE -> IDLE; no new accept in that same cycle.
//   in_valid while busy is ignored; the requester must hold it.
//   ADD: {C,result}=a+b. SUB: result=a-b, C=borrow (a<b unsigned).
//   V = signed overflow for ADD/SUB, else 0. N = result[WIDTH-1]. Z = (result==0),
//     for MUL Z = ({result_hi,result}==0).
//   SLL/SRL: logical shift; C = last bit shifted out (0 for shift amount 0).
//   MUL: unsigned, 2*WIDTH-bit product {result_hi,result}; C = (result_hi!=0); V=0.
//   MUL_EN=0 with op=MUL: DONE next cycle, result=result_hi=0, flags=0, err=1.
//   err clears on the next accept. Operand changes after accept do not affect the op.
//   Reset mid-CALC aborts; no result is emitted.
// STRUCTURE
//   alu_pkg: op localparams (OP_ADD..OP_MUL), FSM state encodings, flag bit indices.
//   Sub-module alu_mul_iter (WIDTH): start/done, shift-add, one partial product per
//     cycle; instantiated only when MUL_EN=1 (generate).
//   Top: FSM, operand latch, combinational 1-cycle datapath, output registers.
// TESTING (WIDTH=8 unless noted)
//   1. ADD a=0xFF,b=0x01 -> out_valid 1 cycle after accept, result=0x00, flags C=1,Z=1,V=0,N=0.
//   2. SUB a=0x80,b=0x01 -> result=0x7F, V=1, C=0, N=0; SUB 0x01-0x02 -> 0xFF, C=1, N=1.
//   3. MUL a=0xFF,b=0xFF -> out_valid 9 cycles after accept, {hi,lo}=0xFE01, C=1;
//      in_ready=0 throughout.
//   4. Backpressure: out_ready=0 for 5 cycles after XOR 0xA5^0x0F -> 0xAA held stable;
//      in_valid pulses ignored; release -> IDLE, next request accepted.
//   5. SLL a=0x81,b=0x01 -> 0x02, C=1; SRL a=0x81,b=0x09 -> amount 1, 0x40, C=1.
//   6. Reset asserted mid-MUL (cycle 4) -> outputs 0 immediately, no out_valid after release;
//      MUL_EN=0 build: MUL -> err=1, result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: opcodes, FSM states and flag layout.
package alu_pkg;

  // Opcode encodings carried on the 3-bit op port.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  // Control FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit positions inside the flags word {N,V,C,Z}.
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  // Assemble the flags word in its architectural order.
  function automatic logic [3:0] pack_flags(input logic n, input logic v, input logic c,
                                            input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product accumulated per cycle.
// The product is presented combinationally during the last step so the caller can
// register it on the same edge that retires the final bit.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] sum;

  // Partial product for the current multiplier bit and the running sum including it.
  always_comb begin
    partial = mplier_q[0] ? mcand_q : '0;
    sum     = acc_q + partial;
  end

  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product = sum;

  // Operand capture on start, then one shift-add step per cycle until the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= sum;
      mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      cnt_q    <= cnt_q + CW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on request and result sides.
// Single-cycle ops are computed from the request inputs and registered on accept;
// MUL is handed to the iterative engine and retired from the CALC state.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int unsigned SW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [3:0]         flags_q, flags_d;
  logic               err_q, err_d;

  logic               accept;
  logic               mul_req;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   mul_lo;
  logic [WIDTH-1:0]   mul_hi;
  logic [3:0]         mul_flags;

  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     add_wide;
  logic [WIDTH:0]     sub_wide;
  logic [WIDTH:0]     sll_wide;
  logic [WIDTH:0]     srl_wide;
  logic [WIDTH-1:0]   dp_res;
  logic               dp_v;
  logic               dp_c;
  logic               dp_err;
  logic [3:0]         dp_flags;

  assign accept    = in_valid & ready_q;
  assign mul_req   = (op == OP_MUL) && MUL_EN;
  assign mul_start = accept & mul_req;
  assign shamt     = b[SW-1:0];

  // Single-cycle datapath evaluated on the request operands.
  always_comb begin
    add_wide = {1'b0, a} + {1'b0, b};
    sub_wide = {1'b0, a} - {1'b0, b};
    // Extra bit above/below the word catches the last bit shifted out.
    sll_wide = {1'b0, a} << shamt;
    srl_wide = {a, 1'b0} >> shamt;
    dp_res   = '0;
    dp_v     = 1'b0;
    dp_c     = 1'b0;
    dp_err   = 1'b0;
    case (op)
      OP_ADD: begin
        dp_res = add_wide[WIDTH-1:0];
        dp_c   = add_wide[WIDTH];
        dp_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_wide[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        dp_res = sub_wide[WIDTH-1:0];
        dp_c   = sub_wide[WIDTH];
        dp_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_wide[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: dp_res = a & b;
      OP_OR:  dp_res = a | b;
      OP_XOR: dp_res = a ^ b;
      OP_SLL: begin
        dp_res = sll_wide[WIDTH-1:0];
        dp_c   = sll_wide[WIDTH];
      end
      OP_SRL: begin
        dp_res = srl_wide[WIDTH:1];
        dp_c   = srl_wide[0];
      end
      default: dp_err = !MUL_EN;
    endcase
    // An unsupported MUL reports all-zero flags, including Z.
    dp_flags = dp_err ? 4'b0000 : pack_flags(dp_res[WIDTH-1], dp_v, dp_c, dp_res == '0);
  end

  if (MUL_EN) begin : g_mul
    alu_mul_iter #(
      .WIDTH (WIDTH)
    ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
    );
  end else begin : g_no_mul
    assign mul_done    = 1'b0;
    assign mul_product = '0;
  end

  // MUL flags: Z covers the full double-width product, C marks a non-zero high word.
  always_comb begin
    mul_lo    = mul_product[WIDTH-1:0];
    mul_hi    = mul_product[2*WIDTH-1:WIDTH];
    mul_flags = pack_flags(mul_lo[WIDTH-1], 1'b0, |mul_hi, mul_product == '0);
  end

  // Next-state and output-register updates for the control FSM.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    err_d       = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          err_d = dp_err;
          if (mul_req) begin
            state_d = StCalc;
          end else begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            result_d    = dp_res;
            result_hi_d = '0;
            flags_d     = dp_flags;
          end
        end
      end
      StCalc: begin
        if (mul_done) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          result_d    = mul_lo;
          result_hi_d = mul_hi;
          flags_d     = mul_flags;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered so in_ready stays low through reset and rises one clock after release.
    ready_d = (state_d == StIdle);
  end

  // State and output registers; reset also aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule
